// File: rtl/fxu_pipe.sv
// fxu_pipe -- registered fixed-point execution unit for the out-of-order core.
//
// Sits between the FXU reservation station (issue side) and the ROB/CDB
// writeback arbiter (result side). Adds valid/ready handshakes on both sides,
// a single registered result stage with backpressure, a synchronous flush,
// and illegal-opcode / signed-overflow reporting.
//
// Optional feature macro: FXU_MUL_EN
//   defined   -> opcode 0010 runs an iterative shift-add multiply (DATA_W cycles)
//   undefined -> no multiplier is built, opcode 0010 is reported illegal, busy=0
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous kill of all in-flight work
//   in_valid/in_ready   issue handshake
//   in_opcode           0000 add, 0001 sub, 0010 mul, 0100 mov, 0101 movl, 0110 movh
//   in_rob              ROB index of the issued instruction
//   in_vt, in_va, in_vb destination old value, operand a, operand b
//   in_imm              DATA_W/2-bit immediate
//   out_valid/out_ready result handshake
//   out_rob, out_value  ROB index and result
//   out_ovf             signed overflow (add/sub only)
//   out_illegal         opcode not supported
//   busy                multiply in progress
module fxu_pipe #(
  parameter int DATA_W = 16,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [ROB_W-1:0]  in_rob,
  input  logic [DATA_W-1:0] in_vt,
  input  logic [DATA_W-1:0] in_va,
  input  logic [DATA_W-1:0] in_vb,
  input  logic [DATA_W/2-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROB_W-1:0]  out_rob,
  output logic [DATA_W-1:0] out_value,
  output logic              out_ovf,
  output logic              out_illegal,
  output logic              busy
);

  localparam int H = DATA_W / 2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_MOVL = 4'b0101;
  localparam logic [3:0] OP_MOVH = 4'b0110;
`ifdef FXU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b0010;
`endif

  // Signed overflow: for add the operand signs match, for sub they differ,
  // and in both cases the result sign differs from operand a.
  function automatic logic ovf_f(input logic is_sub, input logic a_msb,
                                 input logic b_msb, input logic r_msb);
    logic signs_agree;
    signs_agree = is_sub ? (a_msb != b_msb) : (a_msb == b_msb);
    return signs_agree && (r_msb != a_msb);
  endfunction

  // Result register
  logic              out_valid_q, out_valid_d;
  logic [ROB_W-1:0]  out_rob_q, out_rob_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_illegal_q, out_illegal_d;

  // Combinational ALU outputs
  logic [DATA_W-1:0] alu_value_s;
  logic              alu_ovf_s;
  logic              alu_illegal_s;
  logic              is_mul_s;

  logic idle_s;
  logic accept_s;
  logic xfer_s;

`ifdef FXU_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // The multiply keeps its own ROB tag: the result register may still be
  // draining an older result when the multiply is accepted.
  logic [ROB_W-1:0]  mul_rob_q, mul_rob_d;

  assign idle_s = (state_q == ST_IDLE);
  assign busy   = (state_q == ST_MUL);
`else
  assign idle_s = 1'b1;
  assign busy   = 1'b0;
`endif

  // rst_n is included so in_ready is low throughout reset.
  assign in_ready = rst_n && idle_s && !flush && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  assign xfer_s   = out_valid_q && out_ready;

  // Decode and single-cycle ALU evaluation of the issue-side operands.
  always_comb begin
    alu_value_s   = {DATA_W{1'b0}};
    alu_ovf_s     = 1'b0;
    alu_illegal_s = 1'b0;
    is_mul_s      = 1'b0;
    case (in_opcode)
      OP_ADD: begin
        alu_value_s = in_va + in_vb;
        alu_ovf_s   = ovf_f(1'b0, in_va[DATA_W-1], in_vb[DATA_W-1], alu_value_s[DATA_W-1]);
      end
      OP_SUB: begin
        alu_value_s = in_va - in_vb;
        alu_ovf_s   = ovf_f(1'b1, in_va[DATA_W-1], in_vb[DATA_W-1], alu_value_s[DATA_W-1]);
      end
      OP_MOV:  alu_value_s = in_va;
      OP_MOVL: alu_value_s = {in_vt[DATA_W-1:H], in_imm};
      OP_MOVH: alu_value_s = {in_imm, in_vt[H-1:0]};
`ifdef FXU_MUL_EN
      OP_MUL:  is_mul_s = 1'b1;
`endif
      default: alu_illegal_s = 1'b1;
    endcase
  end

  // Next-state for the result register and (optionally) the multiply FSM.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_rob_d     = out_rob_q;
    out_value_d   = out_value_q;
    out_ovf_d     = out_ovf_q;
    out_illegal_d = out_illegal_q;
`ifdef FXU_MUL_EN
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mul_rob_d = mul_rob_q;
`endif
    if (flush) begin
      // Flush beats everything, including a same-cycle transfer or accept.
      out_valid_d = 1'b0;
`ifdef FXU_MUL_EN
      state_d = ST_IDLE;
`endif
    end else begin
      if (xfer_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
`ifdef FXU_MUL_EN
      if (state_q == ST_MUL) begin
        // One multiplier bit per cycle, LSB first.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : {DATA_W{1'b0}});
        mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          // Result register is known empty here: nothing loads it during MUL.
          state_d       = ST_IDLE;
          out_valid_d   = 1'b1;
          out_value_d   = acc_d;
          out_rob_d     = mul_rob_q;
          out_ovf_d     = 1'b0;
          out_illegal_d = 1'b0;
        end else begin
          state_d = ST_MUL;
        end
      end else if (accept_s && is_mul_s) begin
        state_d   = ST_MUL;
        mcand_d   = in_va;
        mplier_d  = in_vb;
        acc_d     = {DATA_W{1'b0}};
        cnt_d     = {CNT_W{1'b0}};
        mul_rob_d = in_rob;
      end else if (accept_s) begin
        out_valid_d   = 1'b1;
        out_rob_d     = in_rob;
        out_value_d   = alu_value_s;
        out_ovf_d     = alu_ovf_s;
        out_illegal_d = alu_illegal_s;
      end else begin
        state_d = state_q;
      end
`else
      if (accept_s) begin
        out_valid_d   = 1'b1;
        out_rob_d     = in_rob;
        out_value_d   = alu_value_s;
        out_ovf_d     = alu_ovf_s;
        out_illegal_d = alu_illegal_s;
      end else begin
        out_rob_d = out_rob_q;
      end
`endif
    end
  end

  // Result register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_rob_q     <= {ROB_W{1'b0}};
      out_value_q   <= {DATA_W{1'b0}};
      out_ovf_q     <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_rob_q     <= out_rob_d;
      out_value_q   <= out_value_d;
      out_ovf_q     <= out_ovf_d;
      out_illegal_q <= out_illegal_d;
    end
  end

`ifdef FXU_MUL_EN
  // Multiply FSM state and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= {DATA_W{1'b0}};
      mplier_q  <= {DATA_W{1'b0}};
      acc_q     <= {DATA_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      mul_rob_q <= {ROB_W{1'b0}};
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mul_rob_q <= mul_rob_d;
    end
  end
`endif

  assign out_valid   = out_valid_q;
  assign out_rob     = out_rob_q;
  assign out_value   = out_value_q;
  assign out_ovf     = out_ovf_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_fxu_pipe.sv
// Directed self-checking bench for fxu_pipe (DATA_W=16, ROB_W=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fxu_pipe;

  localparam int DATA_W = 16;
  localparam int ROB_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [ROB_W-1:0]  in_rob;
  logic [DATA_W-1:0] in_vt, in_va, in_vb;
  logic [DATA_W/2-1:0] in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [ROB_W-1:0]  out_rob;
  logic [DATA_W-1:0] out_value;
  logic              out_ovf;
  logic              out_illegal;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fxu_pipe #(.DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rob(in_rob), .in_vt(in_vt), .in_va(in_va), .in_vb(in_vb), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob),
    .out_value(out_value), .out_ovf(out_ovf), .out_illegal(out_illegal),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rob, input logic [15:0] vt,
                       input logic [15:0] va, input logic [15:0] vb, input logic [7:0] imm);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rob    = rob;
    in_vt     = vt;
    in_va     = va;
    in_vb     = vb;
    in_imm    = imm;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_result(input string tag, input logic [3:0] rob, input logic [15:0] val,
                            input logic ovf, input logic ill);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_value"}, {16'd0, out_value}, {16'd0, val});
    chk({tag, "_rob"}, {28'd0, out_rob}, {28'd0, rob});
    chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
    chk({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, ill});
  endtask

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seen_valid;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_opcode = 4'd0; in_rob = 4'd0;
    in_vt = 16'd0; in_va = 16'd0; in_vb = 16'd0; in_imm = 8'd0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_value", {16'd0, out_value}, 32'd0);
    chk("rst_out_rob", {28'd0, out_rob}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // add with signed overflow
    drive(4'b0000, 4'd3, 16'h0000, 16'h7FFF, 16'h0001, 8'h00);
    tick(); in_valid = 1'b0;
    chk_result("add", 4'd3, 16'h8000, 1'b1, 1'b0);

    // sub without overflow
    drive(4'b0001, 4'd4, 16'h0000, 16'h0005, 16'h0007, 8'h00);
    tick(); in_valid = 1'b0;
    chk_result("sub", 4'd4, 16'hFFFE, 1'b0, 1'b0);

    // sub with overflow (most negative minus one)
    drive(4'b0001, 4'd5, 16'h0000, 16'h8000, 16'h0001, 8'h00);
    tick(); in_valid = 1'b0;
    chk_result("sub_ovf", 4'd5, 16'h7FFF, 1'b1, 1'b0);

    // add wrapping modulo 2^16, no signed overflow
    drive(4'b0000, 4'd6, 16'h0000, 16'hFFFF, 16'h0002, 8'h00);
    tick(); in_valid = 1'b0;
    chk_result("add_wrap", 4'd6, 16'h0001, 1'b0, 1'b0);

    // mov
    drive(4'b0100, 4'd7, 16'h0000, 16'h1234, 16'h5678, 8'h00);
    tick(); in_valid = 1'b0;
    chk_result("mov", 4'd7, 16'h1234, 1'b0, 1'b0);

    // movl / movh back-to-back at full throughput
    drive(4'b0101, 4'd1, 16'hABCD, 16'h0000, 16'h0000, 8'h12);
    tick();
    chk_result("movl", 4'd1, 16'hAB12, 1'b0, 1'b0);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    drive(4'b0110, 4'd2, 16'hABCD, 16'h0000, 16'h0000, 8'h12);
    tick(); in_valid = 1'b0;
    chk_result("movh", 4'd2, 16'h12CD, 1'b0, 1'b0);
    tick();
    chk("drained_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure
    drive(4'b0101, 4'd1, 16'hABCD, 16'h0000, 16'h0000, 8'h12);
    tick();
    drive(4'b0110, 4'd2, 16'hABCD, 16'h0000, 16'h0000, 8'h12);
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_value", {16'd0, out_value}, 32'h0000AB12);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    chk_result("bp_second", 4'd2, 16'h12CD, 1'b0, 1'b0);
    tick();

    // Illegal opcode
    drive(4'b1111, 4'd9, 16'h1111, 16'h2222, 16'h3333, 8'h44);
    tick(); in_valid = 1'b0;
    chk_result("illegal", 4'd9, 16'h0000, 1'b0, 1'b1);
    tick();

    // Flush kills a held result and blocks issue
    drive(4'b0000, 4'd8, 16'h0000, 16'h0001, 16'h0001, 8'h00);
    out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick(); flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);

`ifdef FXU_MUL_EN
    // Iterative multiply
    drive(4'b0010, 4'd10, 16'h0000, 16'h0123, 16'h0010, 8'h00);
    tick(); in_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("mul_busy", {31'd0, busy}, 32'd1);
      chk("mul_no_valid", {31'd0, out_valid}, 32'd0);
      chk("mul_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk_result("mul", 4'd10, 16'h1230, 1'b0, 1'b0);
    chk("mul_done_busy", {31'd0, busy}, 32'd0);
    tick();

    // Multiply abandoned by flush in cycle 5
    drive(4'b0010, 4'd11, 16'h0000, 16'h0123, 16'h0010, 8'h00);
    tick(); in_valid = 1'b0;
    seen_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      if (out_valid) seen_valid++;
      tick();
    end
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("mulflush_busy", {31'd0, busy}, 32'd0);
    chk("mulflush_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (out_valid) seen_valid++;
      tick();
    end
    chk("mulflush_no_result", seen_valid, 32'd0);
`else
    // Without the multiplier, opcode 0010 is illegal
    drive(4'b0010, 4'd10, 16'h0000, 16'h0123, 16'h0010, 8'h00);
    tick(); in_valid = 1'b0;
    chk_result("mul_illegal", 4'd10, 16'h0000, 1'b0, 1'b1);
    chk("mul_illegal_busy", {31'd0, busy}, 32'd0);
    tick();
`endif

    // Asynchronous reset mid-cycle while a result is held
    drive(4'b0100, 4'd12, 16'h0000, 16'h5555, 16'h0000, 8'h00);
    out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    chk("arst_pre_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_out_value", {16'd0, out_value}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_release_in_ready", {31'd0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
